// File: rtl/data_memory.sv
// data_memory: byte-addressable RV32I data memory with clear-on-reset sequence
//   clk      : clock, all state updates on rising edge
//   rst      : asynchronous active-low reset
//   req      : request valid (accepted when req && ready)
//   we       : 1 = store, 0 = load
//   funct3   : RV32I load/store size and sign encoding
//   A        : byte address (word index A[ADDR_W-1:2], lane A[1:0])
//   WD       : right-aligned store data
//   ready    : high in IDLE, request accepted this cycle when req is high
//   busy     : clear sequence in progress
//   rvalid   : load response valid, one cycle after acceptance
//   RD       : formatted load data, held while rvalid is low
//   fault    : one-cycle error pulse for the previously accepted request
module data_memory #(
    parameter int DEPTH          = 16000,
    parameter int ADDR_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] A,
    input  logic [31:0]       WD,
    output logic              ready,
    output logic              busy,
    output logic              rvalid,
    output logic [31:0]       RD,
    output logic              fault
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              rvalid_q, rvalid_d;
    logic              fault_q, fault_d;
    logic [31:0]       rd_q, rd_d;
    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-3:0] widx;
    logic [IW-1:0]     mi;
    logic [1:0]        lane;
    logic              accept, oob, illegal, mis, bad;
    logic [31:0]       word, ld, wdata;
    logic [7:0]        bv;
    logic [15:0]       hv;
    logic [3:0]        be;

    assign widx = A[ADDR_W-1:2];
    assign mi   = widx[IW-1:0];
    assign lane = A[1:0];

    // ready also depends on rst so it reads 0 during reset even when reset lands in IDLE
    assign ready  = rst && state_q == IDLE;
    assign busy   = state_q == CLEAR;
    assign rvalid = rvalid_q;
    assign fault  = fault_q;
    assign RD     = rd_q;

    always_comb begin
        accept  = req && ready;
        oob     = 64'(widx) >= 64'(DEPTH);
        illegal = we ? funct3 > 3'b010 : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
        mis     = (funct3[1:0] == 2'b01 && A[0]) || (funct3[1:0] == 2'b10 && A[1:0] != 2'b00);
        bad     = oob || illegal || mis;
        word    = mem[mi];
        bv      = word[8*lane +: 8];
        hv      = word[16*lane[1] +: 16];
        ld      = funct3 == 3'b000 ? {{24{bv[7]}}, bv} :
                  funct3 == 3'b001 ? {{16{hv[15]}}, hv} :
                  funct3 == 3'b100 ? {24'b0, bv} :
                  funct3 == 3'b101 ? {16'b0, hv} : word;
        // store data is replicated across lanes so the byte enables alone pick the target bytes
        be      = funct3[1:0] == 2'b00 ? 4'b0001 << lane :
                  funct3[1:0] == 2'b01 ? 4'b0011 << lane : 4'b1111;
        wdata   = funct3[1:0] == 2'b00 ? {4{WD[7:0]}} :
                  funct3[1:0] == 2'b01 ? {2{WD[15:0]}} : WD;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rvalid_d = accept && !we;
        fault_d  = accept && bad;
        rd_d     = rvalid_d ? (bad ? 32'b0 : ld) : rd_q;
        if (state_q == CLEAR) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IW'(DEPTH - 1)) begin
                state_d = IDLE;
                idx_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= CLEAR_ON_RESET ? CLEAR : IDLE;
            idx_q    <= '0;
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rvalid_q <= rvalid_d;
            fault_q  <= fault_d;
            rd_q     <= rd_d;
        end
    end

    // storage has no reset; zeroing only happens through the CLEAR walk
    always_ff @(posedge clk) begin
        if (rst && state_q == CLEAR) begin
            mem[idx_q] <= '0;
        end else if (accept && we && !bad) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[mi][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed vector bench for data_memory (DEPTH=64, CLEAR_ON_RESET=1)
module tb_data_memory;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] A = 32'b0;
    logic [31:0] WD = 32'b0;
    logic        ready, busy, rvalid, fault;
    logic [31:0] RD;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic        rv;
        logic        flt;
        logic [31:0] rd;
    } vec_t;

    data_memory #(.DEPTH(64), .ADDR_W(32), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .A(A), .WD(WD),
        .ready(ready), .busy(busy), .rvalid(rvalid), .RD(RD), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_rd"}, RD, 32'd0);
    endtask

    // counts cycles with busy high, starting from a negedge; flags any response seen while busy
    task automatic count_busy(output int n, output int spur);
        n = 0;
        spur = 0;
        while (busy && n < 200) begin
            if (rvalid || fault) spur++;
            n++;
            @(negedge clk);
        end
        req = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        req = 1'b1;
        we = v.we;
        funct3 = v.f3;
        A = v.a;
        WD = v.wd;
        @(negedge clk);
    endtask

    vec_t vecs[$];
    vec_t t;
    logic [31:0] last_rd;
    int n, spur;

    initial begin
        vecs.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 3'b010, 32'h20, 32'h800000FF, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 3'b000, 32'h20, 32'h0, 1'b1, 1'b0, 32'hFFFFFFFF});
        vecs.push_back('{1'b0, 3'b100, 32'h20, 32'h0, 1'b1, 1'b0, 32'h000000FF});
        vecs.push_back('{1'b0, 3'b001, 32'h22, 32'h0, 1'b1, 1'b0, 32'hFFFF8000});
        vecs.push_back('{1'b0, 3'b101, 32'h22, 32'h0, 1'b1, 1'b0, 32'h00008000});
        vecs.push_back('{1'b1, 3'b010, 32'h20, 32'h11223344, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 3'b000, 32'h21, 32'h000000AB, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 1'b0, 32'h1122AB44});
        vecs.push_back('{1'b1, 3'b010, 32'h22, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 1'b0, 32'h1122AB44});
        vecs.push_back('{1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 3'b001, 32'h21, 32'h0, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 3'b011, 32'h20, 32'h0, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 1'b0, 32'h1122AB44});
        vecs.push_back('{1'b1, 3'b001, 32'h26, 32'h1234BEEF, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 3'b010, 32'h24, 32'h0, 1'b1, 1'b0, 32'hBEEF0000});
        vecs.push_back('{1'b0, 3'b000, 32'h27, 32'h0, 1'b1, 1'b0, 32'hFFFFFFBE});
        vecs.push_back('{1'b1, 3'b011, 32'h28, 32'h55555555, 1'b0, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 3'b010, 32'h28, 32'h0, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 3'b000, 32'h23, 32'h0000007F, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 3'b000, 32'h23, 32'h0, 1'b1, 1'b0, 32'h0000007F});
        vecs.push_back('{1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 1'b0, 32'h7F22AB44});
        vecs.push_back('{1'b1, 3'b010, 32'hFC, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 3'b101, 32'hFE, 32'h0, 1'b1, 1'b0, 32'h0000CAFE});
        vecs.push_back('{1'b1, 3'b001, 32'h100, 32'hFFFF, 1'b0, 1'b1, 32'h0});

        #3;
        chk_reset("rst0");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        count_busy(n, spur);
        chk("clear_len", 32'(n), 32'd64);
        chk("clear_spur", 32'(spur), 32'd0);
        chk("ready_after", 32'(ready), 32'd1);

        last_rd = 32'h0;
        for (int i = 0; i < vecs.size(); i++) begin
            t = vecs[i];
            drive(t);
            chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(t.rv));
            chk($sformatf("v%0d_fault", i), 32'(fault), 32'(t.flt));
            if (t.rv) last_rd = t.rd;
            chk($sformatf("v%0d_rd", i), RD, last_rd);
        end
        req = 1'b0;
        @(negedge clk);
        chk("idle_rvalid", 32'(rvalid), 32'd0);
        chk("idle_fault", 32'(fault), 32'd0);
        chk("idle_rd_hold", RD, last_rd);

        // reset with a load response in flight discards it
        t = '{1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0};
        req = 1'b1;
        we = 1'b0;
        funct3 = 3'b010;
        A = 32'h20;
        @(posedge clk);
        #1;
        chk("pend_rvalid", 32'(rvalid), 32'd1);
        rst = 1'b0;
        #1;
        chk_reset("rst1");
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // store requests during CLEAR must be ignored; abort clear at cycle 30
        req = 1'b1;
        we = 1'b1;
        funct3 = 3'b010;
        A = 32'h0;
        WD = 32'h55;
        rst = 1'b1;
        n = 0;
        spur = 0;
        while (busy && n < 30) begin
            if (rvalid || fault) spur++;
            n++;
            @(negedge clk);
        end
        chk("abort_at", 32'(n), 32'd30);
        rst = 1'b0;
        #1;
        chk_reset("rst2");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk("spur_pre", 32'(spur), 32'd0);
        count_busy(n, spur);
        chk("reclear_len", 32'(n), 32'd64);
        chk("reclear_spur", 32'(spur), 32'd0);
        chk("reclear_rvalid", 32'(rvalid), 32'd0);
        chk("reclear_fault", 32'(fault), 32'd0);
        chk("reclear_ready", 32'(ready), 32'd1);

        t = '{1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0};
        drive(t);
        chk("w0_rvalid", 32'(rvalid), 32'd1);
        chk("w0_rd", RD, 32'h0);
        t = '{1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0};
        drive(t);
        chk("w8_rvalid", 32'(rvalid), 32'd1);
        chk("w8_rd", RD, 32'h0);
        req = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 16000, meaning number of 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1, meaning zero-fill all words after reset release.
REQ-004 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset; asserted when 0.
REQ-006 SHALL have port req, input, 1, request valid.
REQ-007 SHALL have port we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port funct3, input, 3, access size and sign (RV32I load/store encoding).
REQ-009 SHALL have port A, input, ADDR_W, byte address.
REQ-010 SHALL have port WD, input, 32, store data, right-aligned.
REQ-011 SHALL have port ready, output, 1, request accepted this cycle when req && ready.
REQ-012 SHALL have port busy, output, 1, clear sequence in progress.
REQ-013 SHALL have port rvalid, output, 1, load response valid.
REQ-014 SHALL have port RD, output, 32, formatted load data.
REQ-015 SHALL have port fault, output, 1, one-cycle error pulse for the previously accepted request.

Function
REQ-016 SHALL implement a two-state FSM: CLEAR and IDLE; ready = 1 only in IDLE; busy = 1 only in CLEAR.
REQ-017 SHALL leave reset in CLEAR with clear index 0 when CLEAR_ON_RESET=1, otherwise in IDLE.
REQ-018 SHALL, in CLEAR, write 0 to word[index] each cycle, increment the index, and enter IDLE after writing word DEPTH-1: exactly DEPTH busy cycles.
REQ-019 SHALL ignore req while in CLEAR: no write, no response.
REQ-020 SHALL use word index A[ADDR_W-1:2] and byte lane A[1:0].
REQ-021 SHALL flag an accepted request as faulting if the word index is >= DEPTH.
REQ-022 SHALL flag an accepted request as faulting on misalignment: halfword with A[0]=1, or word with A[1:0]!=0.
REQ-023 SHALL flag an accepted request as faulting on an illegal funct3: for loads 011, 110, 111; for stores anything other than 000, 001, 010.
REQ-024 SHALL, on an accepted non-faulting store, update at that clock edge only the addressed bytes: SB 1 lane, SH 2 lanes, SW 4 lanes; other bytes unchanged.
REQ-025 SHALL never modify memory on a faulting store.
REQ-026 SHALL give loads a latency of one cycle: rvalid = 1 in the cycle after acceptance, for exactly one cycle per accepted load.
REQ-027 SHALL format RD per funct3: LB sign-extend, LH sign-extend, LW, LBU zero-extend, LHU zero-extend, selected from lane A[1:0].
REQ-028 SHALL hold RD at its last value when rvalid = 0.
REQ-029 SHALL, on a faulting load, still assert rvalid with RD = 0 and fault = 1.
REQ-030 SHALL, on a faulting store, assert fault = 1 in the next cycle with rvalid = 0.
REQ-031 SHALL return the stored data when a load is accepted in the cycle immediately after a store to the same word.
REQ-032 SHALL accept back-to-back requests every cycle in IDLE with no bubbles.

Reset
REQ-033 SHALL, while rst = 0, force ready=0, rvalid=0, fault=0, RD=0, clear index 0, and busy=CLEAR_ON_RESET.
REQ-034 SHALL treat rst asserted mid-CLEAR as aborting the sequence, which restarts from index 0 on release.
REQ-035 SHALL treat rst asserted with a response pending as discarding the response: no rvalid or fault after release.
REQ-036 SHALL not reset memory contents asynchronously; zeroing happens only via CLEAR.

Verification (DEPTH=64, CLEAR_ON_RESET=1)
REQ-037 SHALL cover: release rst -> busy=1 for exactly 64 cycles, ready rises next; LW A=0x10 -> rvalid next cycle, RD=0x00000000.
REQ-038 SHALL cover: SW 0x800000FF @0x20, then LB 0x20 -> 0xFFFFFFFF; LBU 0x20 -> 0x000000FF; LH 0x22 -> 0xFFFF8000; LHU 0x22 -> 0x00008000.
REQ-039 SHALL cover: SW 0x11223344 @0x20, SB WD=0x000000AB @0x21, LW 0x20 the next cycle -> 0x1122AB44.
REQ-040 SHALL cover: SW 0xDEADBEEF @0x22 -> fault pulse 1 cycle, rvalid=0; subsequent LW 0x20 returns the prior value unchanged.
REQ-041 SHALL cover: LW @0x100 (word 64) -> rvalid=1, fault=1, RD=0; LH @0x21 -> fault=1; load with funct3=011 -> fault=1.
REQ-042 SHALL cover: rst low at clear cycle 30, released after 3 cycles -> busy for a full 64 cycles; a req during busy produces no response.
